// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_basic between NUM_REQ byte streams.
// The owner keeps the transmitter until it sends a byte flagged last (or goes idle too long).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int LOCK_TO = 1024,
  parameter int BUSY_TO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   grant_active,
  output logic [IDW-1:0]         grant_id,
  output logic                   err_pulse
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OWN     = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;

  localparam int IC_W = $clog2(LOCK_TO + 1);
  localparam int BC_W = $clog2(BUSY_TO + 1);
  localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(LOCK_TO - 1);
  localparam logic [BC_W-1:0] BUSY_LAST = BC_W'(BUSY_TO - 1);
  localparam logic [IDW-1:0]  RR_INIT   = IDW'(NUM_REQ - 1);

  logic [2:0]      state;
  logic [IDW-1:0]  rr;
  logic            last_q;
  logic [IC_W-1:0] idle_cnt;
  logic [BC_W-1:0] busy_cnt;

  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            accept;
  logic            busy_timeout;
  logic            byte_done;
  logic            lock_timeout;
  logic            release_lock;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  scan_idx;

  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign own_data  = req_data[{grant_id, 3'b000} +: 8];

  assign accept    = (state == S_OWN) && own_valid && !tx_busy;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign tx_start  = (state == S_START);

  // START counts as the first of the BUSY_TO cycles spent waiting for busy
  assign busy_timeout = (state == S_WAIT_HI) && !tx_busy && (busy_cnt == BUSY_LAST);
  assign byte_done    = ((state == S_WAIT_LO) && !tx_busy) || busy_timeout;
  assign lock_timeout = (state == S_OWN) && !own_valid && (idle_cnt == IDLE_LAST);
  assign release_lock = lock_timeout || (byte_done && last_q);

  // Scan from farthest to nearest so the requester right after rr wins
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = IDW'((int'(rr) + i) % NUM_REQ);
      if (req_valid[scan_idx]) win_id = scan_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr           <= RR_INIT;
      grant_active <= 1'b0;
      grant_id     <= '0;
      tx_data      <= '0;
      last_q       <= 1'b0;
      idle_cnt     <= '0;
      busy_cnt     <= '0;
      err_pulse    <= 1'b0;
    end else begin
      err_pulse <= lock_timeout || busy_timeout;

      if (release_lock) begin
        rr           <= grant_id;
        grant_active <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grant_id     <= win_id;
            grant_active <= 1'b1;
            idle_cnt     <= '0;
            state        <= S_OWN;
          end
        end
        S_OWN: begin
          if (accept) begin
            tx_data  <= own_data;
            last_q   <= own_last;
            idle_cnt <= '0;
            state    <= S_START;
          end else if (lock_timeout) begin
            idle_cnt <= '0;
            state    <= S_IDLE;
          end else if (!own_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_START: begin
          busy_cnt <= BC_W'(1);
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            state <= S_WAIT_LO;
          end else if (busy_timeout) begin
            state <= last_q ? S_IDLE : S_OWN;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) state <= last_q ? S_IDLE : S_OWN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART busy model.
// Stimulus queues bytes per requester; a monitor checks every tx_start against expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int LOCK_TO = 16;
  localparam int BUSY_TO = 4;
  localparam int FRAME   = 20;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 grant_active;
  logic [IDW-1:0]       grant_id;
  logic                 err_pulse;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDW(IDW), .LOCK_TO(LOCK_TO), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_active(grant_active), .grant_id(grant_id), .err_pulse(err_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural transmitter: busy rises the cycle after start and lasts FRAME cycles
  logic busy_dead;
  int   frame_cnt;
  always @(posedge clk) begin
    if (rst) begin
      tx_busy   <= 1'b0;
      frame_cnt <= 0;
    end else if (busy_dead) begin
      tx_busy <= 1'b0;
    end else if (!tx_busy && tx_start) begin
      tx_busy   <= 1'b1;
      frame_cnt <= FRAME - 1;
    end else if (tx_busy) begin
      if (frame_cnt == 0) tx_busy <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  logic [8:0] pend [NUM_REQ][$];
  int         n_tests;
  int         n_fail;
  int         err_cnt;
  int         start_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last);
    pend[k].push_back({last, d});
  endtask

  task automatic expect_byte(input int k, input logic [7:0] d);
    exp_t e;
    e.id   = IDW'(k);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock: present queue heads at negedge, pop whatever was accepted at posedge
  task automatic step();
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [8*NUM_REQ-1:0] d;
    logic [NUM_REQ-1:0]   fire;
    logic [NUM_REQ-1:0]   sh;
    @(negedge clk);
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pend[k].size() > 0) begin
        v = v | (NUM_REQ'(1) << k);
        l = l | (NUM_REQ'(pend[k][0][8]) << k);
        d = d | ((8*NUM_REQ)'(pend[k][0][7:0]) << (8*k));
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
    #3;
    fire = req_valid & req_ready;
    @(posedge clk);
    for (int k = 0; k < NUM_REQ; k++) begin
      sh = fire >> k;
      if (sh[0]) void'(pend[k].pop_front());
    end
    #1;
  endtask

  function automatic bit idle_now();
    bit empty;
    empty = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) if (pend[k].size() != 0) empty = 1'b0;
    return empty && (exp_q.size() == 0) && (grant_active === 1'b0) && (tx_busy === 1'b0);
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!idle_now() && n < 3000) begin
      step();
      n++;
    end
    check({name, "_drained"}, 32'(idle_now()), 32'd1);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_grant_active"}, 32'(grant_active), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
  endtask

  // Monitor: samples just before the active edge, after stimulus has settled
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst !== 1'b0) continue;
      if (err_pulse === 1'b1) err_cnt++;
      if (tx_start === 1'b1) begin
        start_cnt++;
        check("start_while_busy", 32'(tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got byte 0x%0h from id %0d, want no start", tx_data, grant_id);
        end else begin
          e_mon = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e_mon.data));
          check("tx_owner", 32'(grant_id), 32'(e_mon.id));
        end
      end
      if (req_ready !== '0) begin
        check("ready_onehot_owner", 32'(req_ready), 32'(NUM_REQ'(1) << grant_id));
        check("ready_needs_grant", 32'(grant_active), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    n_tests   = 0;
    n_fail    = 0;
    err_cnt   = 0;
    start_cnt = 0;
    busy_dead = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single byte from requester 0 (rr starts at NUM_REQ-1)
    push(0, 8'h55, 1'b1);
    expect_byte(0, 8'h55);
    drain("single");

    // Locked message from req1 while req2 waits
    push(1, 8'h48, 1'b0);
    push(1, 8'h69, 1'b0);
    push(1, 8'h21, 1'b1);
    push(2, 8'hAA, 1'b1);
    expect_byte(1, 8'h48);
    expect_byte(1, 8'h69);
    expect_byte(1, 8'h21);
    expect_byte(2, 8'hAA);
    drain("locked");

    // Round robin: rr is now 2, so requester 3 is served first
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < NUM_REQ; k++) push(k, 8'h10 + 8'(k), 1'b1);
    for (int rep = 0; rep < 2; rep++) begin
      expect_byte(3, 8'h13);
      expect_byte(0, 8'h10);
      expect_byte(1, 8'h11);
      expect_byte(2, 8'h12);
    end
    drain("round_robin");
    check("no_err_in_normal_traffic", 32'(err_cnt), 32'd0);

    // Lock timeout: req3 sends a non-last byte then goes quiet
    push(3, 8'h01, 1'b0);
    expect_byte(3, 8'h01);
    n = 0;
    while (tx_start !== 1'b1 && n < 100) begin step(); n++; end
    check("lock_start_seen", 32'(tx_start), 32'd1);
    push(0, 8'h77, 1'b1);
    expect_byte(0, 8'h77);
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin step(); n++; end
    check("lock_busy_rise", 32'(tx_busy), 32'd1);
    n = 0;
    while (tx_busy !== 1'b0 && n < 100) begin step(); n++; end
    check("lock_busy_fall", 32'(tx_busy), 32'd0);
    // OWN is re-entered one cycle after busy falls; release follows LOCK_TO idle cycles
    n = 0;
    while (err_pulse !== 1'b1 && n < 60) begin step(); n++; end
    check("lock_to_latency", 32'(n), 32'(LOCK_TO + 1));
    check("lock_released", 32'(grant_active), 32'd0);
    drain("lock_timeout");
    check("lock_err_count", 32'(err_cnt), 32'd1);

    // Busy timeout: transmitter never raises busy
    busy_dead = 1'b1;
    push(1, 8'h3C, 1'b0);
    push(1, 8'hC3, 1'b1);
    expect_byte(1, 8'h3C);
    expect_byte(1, 8'hC3);
    n = 0;
    while (tx_start !== 1'b1 && n < 100) begin step(); n++; end
    check("busy_start_seen", 32'(tx_start), 32'd1);
    n = 0;
    while (err_pulse !== 1'b1 && n < 30) begin step(); n++; end
    check("busy_to_latency", 32'(n), 32'(BUSY_TO));
    drain("busy_timeout");
    check("busy_err_count", 32'(err_cnt), 32'd3);
    busy_dead = 1'b0;

    // Reset during the second byte of a three-byte message
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    expect_byte(2, 8'hA1);
    expect_byte(2, 8'hA2);
    s0 = start_cnt;
    n = 0;
    while (start_cnt < s0 + 2 && n < 200) begin step(); n++; end
    check("midframe_two_starts", 32'(start_cnt - s0), 32'd2);
    step();
    step();
    step();
    check("midframe_busy", 32'(tx_busy), 32'd1);
    for (int k = 0; k < NUM_REQ; k++) pend[k].delete();
    rst = 1'b1;
    step();
    check_reset_outputs("midframe_reset");
    check("midframe_no_pending_expect", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;

    push(3, 8'hE7, 1'b1);
    push(0, 8'h5A, 1'b1);
    expect_byte(0, 8'h5A);
    expect_byte(3, 8'hE7);
    n = 0;
    while (grant_active !== 1'b1 && n < 20) begin step(); n++; end
    check("post_reset_grant_active", 32'(grant_active), 32'd1);
    check("post_reset_grant_id", 32'(grant_id), 32'd0);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
